reg_file: RTL

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file_pkg.sv | 60 ++++++
 rtl/reg_file_if.sv | 30 +++
 rtl/reg_file.sv | 111 +++++++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared types for the CPU register file: register selects, write masks and status layout.
package reg_file_pkg;

  typedef enum logic [3:0] {
    R0     = 4'd0,
    R1     = 4'd1,
    R2     = 4'd2,
    R3     = 4'd3,
    R4     = 4'd4,
    R5     = 4'd5,
    R6     = 4'd6,
    R7     = 4'd7,
    R8     = 4'd8,
    R9     = 4'd9,
    R10    = 4'd10,
    SP     = 4'd11,
    LR     = 4'd12,
    PC     = 4'd13,
    PCLINK = 4'd14,
    STATUS = 4'd15
  } reg_e;

  typedef enum logic [1:0] {
    LS8  = 2'd0,
    LS16 = 2'd1,
    LS24 = 2'd2,
    LS32 = 2'd3
  } reg_mask_e;

  typedef enum logic {
    USER       = 1'b0,
    SUPERVISOR = 1'b1
  } cpu_mode_e;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_status_t;

  typedef struct packed {
    cpu_mode_e   mode;
    logic        imask;
    alu_status_t alu_status;
  } status_t;

  localparam int unsigned NUM_GPR = 14;  // R0-R10, SP, LR, PC
  localparam status_t STATUS_RESET = '{mode: SUPERVISOR, imask: 1'b1, alu_status: '0};

  function automatic logic [31:0] mask_32(input reg_mask_e m);
    case (m)
      LS8:     return 32'h0000_00FF;
      LS16:    return 32'h0000_FFFF;
      LS24:    return 32'h00FF_FFFF;
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

endpackage

// File: rtl/reg_file_if.sv
// Register file bus: two read ports, one masked write port, PC advance and ALU flag update.
interface reg_file_if;
  import reg_file_pkg::*;

  reg_e        a_sel;
  logic [31:0] a_data;
  reg_e        b_sel;
  logic [31:0] b_data;
  logic        wr_en;
  reg_e        wr_sel;
  reg_mask_e   wr_mask;
  logic [31:0] wr_data;
  logic        pc_inc;
  logic        flags_wr_en;
  alu_status_t flags_in;
  logic [31:0] pc;
  status_t     status;
  cpu_mode_e   mode;
  logic        imask;

  modport master (
    output a_sel, b_sel, wr_en, wr_sel, wr_mask, wr_data, pc_inc, flags_wr_en, flags_in,
    input  a_data, b_data, pc, status, mode, imask
  );

  modport slave (
    input  a_sel, b_sel, wr_en, wr_sel, wr_mask, wr_data, pc_inc, flags_wr_en, flags_in,
    output a_data, b_data, pc, status, mode, imask
  );
endinterface

// File: rtl/reg_file.sv
// CPU register file with PC/LR linking, privileged STATUS and masked writes.
// Define REG_FILE_BYPASS_EN to forward same-cycle write results to the read ports.
module reg_file
  import reg_file_pkg::*;
(
  input logic       clk,
  input logic       rst,
  reg_file_if.slave bus
);

  logic [31:0] gpr_q [NUM_GPR];
  logic [31:0] gpr_d [NUM_GPR];
  status_t     status_q;
  status_t     status_d;

  logic [31:0] wmask;
  logic [31:0] status_image;
  logic [31:0] status_merged;
  logic        pc_written;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [31:0] m);
    return (old_v & ~m) | (new_v & m);
  endfunction

  function automatic logic [31:0] read_reg(input reg_e sel, input logic [31:0] regs [NUM_GPR],
                                           input status_t st);
    case (sel)
      PCLINK:  return regs[PC];
      STATUS:  return {26'd0, st};
      default: return regs[sel];
    endcase
  endfunction

  assign wmask         = mask_32(bus.wr_mask);
  assign status_image  = {26'd0, status_q};
  assign status_merged = merge(status_image, bus.wr_data, wmask);
  assign pc_written    = bus.wr_en && (bus.wr_sel == PC || bus.wr_sel == PCLINK);

  // NOTE: every variable driven here gets a default first so no path leaves it unassigned,
  // which is what keeps synthesis from inferring latches.
  always_comb begin
    gpr_d    = gpr_q;
    status_d = status_q;

    if (bus.flags_wr_en) status_d.alu_status = bus.flags_in;
    if (bus.pc_inc && !pc_written) gpr_d[PC] = gpr_q[PC] + 32'd1;

    if (bus.wr_en) begin
      case (bus.wr_sel)
        STATUS: begin
          // User code may only touch the ALU flags; mode and imask are privileged.
          if (status_q.mode == SUPERVISOR) status_d = status_t'(status_merged[5:0]);
          else                             status_d.alu_status = alu_status_t'(status_merged[3:0]);
        end
        PCLINK: begin
          gpr_d[PC] = merge(gpr_q[PC], bus.wr_data, wmask);
          gpr_d[LR] = gpr_q[PC];
        end
        default: gpr_d[bus.wr_sel] = merge(gpr_q[bus.wr_sel], bus.wr_data, wmask);
      endcase
    end
  end

  // NOTE: the register bank is built from flops rather than a RAM macro, so it can and
  // does take the asynchronous reset along with everything else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_GPR; i++) gpr_q[i] <= '0;
      status_q <= STATUS_RESET;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values; LR <= PC
      // on a PCLINK write relies on that.
      gpr_q    <= gpr_d;
      status_q <= status_d;
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic [31:0] gpr_v [NUM_GPR];
  status_t     status_v;

  // Only registers touched by this cycle's write are forwarded; pc_inc and flag updates are not.
  always_comb begin
    gpr_v    = gpr_q;
    status_v = status_q;
    if (bus.wr_en) begin
      case (bus.wr_sel)
        STATUS: status_v = status_d;
        PCLINK: begin
          gpr_v[PC] = gpr_d[PC];
          gpr_v[LR] = gpr_d[LR];
        end
        default: gpr_v[bus.wr_sel] = gpr_d[bus.wr_sel];
      endcase
    end
  end

  assign bus.a_data = read_reg(bus.a_sel, gpr_v, status_v);
  assign bus.b_data = read_reg(bus.b_sel, gpr_v, status_v);
`else
  assign bus.a_data = read_reg(bus.a_sel, gpr_q, status_q);
  assign bus.b_data = read_reg(bus.b_sel, gpr_q, status_q);
`endif

  assign bus.pc     = gpr_q[PC];
  assign bus.status = status_q;
  assign bus.mode   = status_q.mode;
  assign bus.imask  = status_q.imask;

endmodule
